// File: rtl/display_scanner_if.sv
// Purpose: groups the load/blanking controls and the scan outputs of the display scanner.
// Latency: wiring only, no storage.
// Backpressure: none; load is a one-cycle request that is always accepted.
interface display_scanner_if;
   logic        load;
   logic [15:0] data_in;
   logic        blank_lz;
   logic [3:0]  bin;
   logic [3:0]  an;
   logic [1:0]  digit_idx;
   logic        pending;
   logic        frame_done;

   // Driver side: issues loads and blanking control, observes the scan.
   modport master (
      output load, data_in, blank_lz,
      input  bin, an, digit_idx, pending, frame_done
   );

   // Scanner side.
   modport slave (
      input  load, data_in, blank_lz,
      output bin, an, digit_idx, pending, frame_done
   );
endinterface

// File: rtl/display_scanner.sv
// Purpose: time-multiplexes four nibbles onto one digit bus with double-buffered, tear-free updates.
// Latency: a load becomes visible at the next frame boundary (same boundary if it coincides with it).
// Backpressure: none; loads are always accepted, a newer load overwrites an unapplied one.
module display_scanner #(
   parameter int unsigned PRESCALE = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   display_scanner_if.slave  bus
);

   localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] r_count;
   logic [1:0]    r_digit_idx;
   logic [15:0]   r_active;
   logic [15:0]   r_shadow;
   logic          r_pending;
   logic          r_frame_done;
   logic          r_blank_lz;

   logic          w_tick;
   logic          w_boundary;
   logic [3:0]    w_bin;
   logic [3:0]    w_an;
   logic [3:0]    w_blank;

   assign w_tick     = (r_count == LAST);
   assign w_boundary = w_tick && (r_digit_idx == 2'd3);

   // Prescaler: one slot per PRESCALE cycles, digit index steps on each slot end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count     <= '0;
         r_digit_idx <= 2'd0;
      end else if (w_tick) begin
         r_count     <= '0;
         r_digit_idx <= r_digit_idx + 2'd1;
      end else begin
         r_count     <= r_count + 1'b1;
      end
   end

   // Double buffer: shadow collects loads, active only changes at the frame boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active  <= 16'h0000;
         r_shadow  <= 16'h0000;
         r_pending <= 1'b0;
      end else if (w_boundary) begin
         r_pending <= 1'b0;
         if (bus.load) begin
            // A load landing on the boundary bypasses the shadow wait.
            r_active <= bus.data_in;
            r_shadow <= bus.data_in;
         end else if (r_pending) begin
            r_active <= r_shadow;
         end
      end else if (bus.load) begin
         r_shadow  <= bus.data_in;
         r_pending <= 1'b1;
      end
   end

   // Frame pulse and registered blanking enable keep every output register-driven.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_done <= 1'b0;
         r_blank_lz   <= 1'b0;
      end else begin
         r_frame_done <= w_boundary;
         r_blank_lz   <= bus.blank_lz;
      end
   end

   // Leading-zero blanking: digit i is dark when it and every higher nibble are zero.
   assign w_blank[0] = 1'b0;
   assign w_blank[1] = r_blank_lz && (r_active[15:4]  == 12'h000);
   assign w_blank[2] = r_blank_lz && (r_active[15:8]  == 8'h00);
   assign w_blank[3] = r_blank_lz && (r_active[15:12] == 4'h0);

   // Nibble mux and one-hot-low anode select from registered state only.
   always_comb begin
      w_bin = 4'h0;
      w_an  = 4'b1111;
      case (r_digit_idx)
         2'd0:    w_bin = r_active[3:0];
         2'd1:    w_bin = r_active[7:4];
         2'd2:    w_bin = r_active[11:8];
         default: w_bin = r_active[15:12];
      endcase
      if (!w_blank[r_digit_idx]) begin
         w_an = ~(4'b0001 << r_digit_idx);
      end
   end

   assign bus.bin        = w_bin;
   assign bus.an         = w_an;
   assign bus.digit_idx  = r_digit_idx;
   assign bus.pending    = r_pending;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scanner.sv
// Purpose: self-checking bench for display_scanner with PRESCALE=4 and a per-cycle scoreboard.
// Latency: expected outputs are queued when inputs are driven and popped one edge later.
// Backpressure: not applicable; every wait is bounded by a cycle budget.
module tb_display_scanner;
   localparam int P = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   display_scanner_if bus();

   display_scanner #(.PRESCALE(P)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int fd_seen  = 0;
   int ones_seen = 0;

   logic [11:0] q[$];

   int          m_cnt;
   logic [1:0]  m_idx;
   logic [15:0] m_act, m_sh;
   logic        m_pend, m_fd, m_blz;

   function automatic logic [3:0] exp_an(logic [1:0] idx, logic [15:0] act, logic blz);
      logic [15:0] upper;
      upper = act >> (4 * idx);
      if (idx != 2'd0 && blz && upper == 16'h0) return 4'hF;
      return ~(4'b0001 << idx);
   endfunction

   function automatic logic [11:0] exp_vec();
      logic [3:0] nib;
      nib = 4'(m_act >> (4 * m_idx));
      return {exp_an(m_idx, m_act, m_blz), nib, m_idx, m_fd, m_pend};
   endfunction

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_idx = 2'd0; m_act = 16'h0; m_sh = 16'h0;
      m_pend = 1'b0; m_fd = 1'b0; m_blz = 1'b0;
   endtask

   // One clock: advance the reference, queue its outputs, compare after the edge.
   task automatic cyc();
      logic tick, bnd;
      logic [11:0] e;
      tick = (m_cnt == P - 1);
      bnd  = tick && (m_idx == 2'd3);
      m_fd = bnd;
      if (bnd) begin
         if (bus.load) begin
            m_act = bus.data_in; m_sh = bus.data_in;
         end else if (m_pend) begin
            m_act = m_sh;
         end
         m_pend = 1'b0;
      end else if (bus.load) begin
         m_sh = bus.data_in; m_pend = 1'b1;
      end
      m_idx = tick ? m_idx + 2'd1 : m_idx;
      m_cnt = tick ? 0 : m_cnt + 1;
      m_blz = bus.blank_lz;
      q.push_back(exp_vec());
      @(posedge clk);
      @(negedge clk);
      e = q.pop_front();
      if (bus.frame_done) fd_seen++;
      if (bus.bin == 4'h1) ones_seen++;
      chk("cycle{an,bin,idx,fd,pend}",
          {4'h0, bus.an, bus.bin, bus.digit_idx, bus.frame_done, bus.pending},
          {4'h0, e});
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wait_state(logic [1:0] idx, int cnt);
      for (int i = 0; i < 40; i++) begin
         if (m_idx == idx && m_cnt == cnt) return;
         cyc();
      end
      checks++; failures++;
      $error("FAIL wait_state_timeout observed=none expected=idx%0d/cnt%0d", idx, cnt);
   endtask

   task automatic wait_fd();
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (m_fd) return;
      end
      checks++; failures++;
      $error("FAIL wait_fd_timeout observed=none expected=frame_done");
   endtask

   task automatic load_word(logic [15:0] d);
      bus.data_in = d; bus.load = 1'b1;
      cyc();
      bus.load = 1'b0;
   endtask

   initial begin
      logic [3:0] nibs [4];
      logic [3:0] ans  [4];
      bus.load = 1'b0; bus.data_in = 16'h0; bus.blank_lz = 1'b0;
      model_reset();

      // Reset values while rst_n is held low.
      #2;
      chk("rst_an", {12'h0, bus.an}, 16'h000E);
      chk("rst_bin", {12'h0, bus.bin}, 16'h0000);
      chk("rst_idx", {14'h0, bus.digit_idx}, 16'h0000);
      chk("rst_pend_fd", {14'h0, bus.pending, bus.frame_done}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle scan: first tick after PRESCALE edges, two frames in 32 clocks.
      fd_seen = 0;
      run(3);
      chk("first_tick_not_yet", {14'h0, bus.digit_idx}, 16'h0000);
      run(1);
      chk("first_tick", {14'h0, bus.digit_idx}, 16'h0001);
      run(28);
      chk("fd_per_32", 16'(fd_seen), 16'd2);

      // Mid-frame load: held pending, applied at boundary, shown B,A,2,1.
      wait_state(2'd1, 1);
      load_word(16'h12AB);
      chk("pend_after_load", {15'h0, bus.pending}, 16'h0001);
      wait_fd();
      chk("pend_clr_at_fd", {15'h0, bus.pending}, 16'h0000);
      nibs = '{4'hB, 4'hA, 4'h2, 4'h1};
      for (int i = 0; i < 4; i++) begin
         chk("bin_12AB", {12'h0, bus.bin}, {12'h0, nibs[i]});
         run(P);
      end

      // Two loads in one frame: last wins, first never shown.
      wait_state(2'd1, 0);
      load_word(16'h1111);
      run(2);
      load_word(16'h2222);
      wait_fd();
      chk("bin_2222_start", {12'h0, bus.bin}, 16'h0002);
      ones_seen = 0;
      run(16);
      chk("no_1111_shown", 16'(ones_seen), 16'd0);

      // Load exactly in the boundary cycle: direct to active, no pending.
      wait_state(2'd3, P - 1);
      load_word(16'hBEEF);
      chk("beef_fd", {15'h0, bus.frame_done}, 16'h0001);
      chk("beef_no_pend", {15'h0, bus.pending}, 16'h0000);
      nibs = '{4'hF, 4'hE, 4'hE, 4'hB};
      for (int i = 0; i < 4; i++) begin
         chk("bin_BEEF", {12'h0, bus.bin}, {12'h0, nibs[i]});
         run(P);
      end

      // Leading-zero blanking on 0045 and 0000.
      bus.blank_lz = 1'b1;
      wait_state(2'd1, 1);
      load_word(16'h0045);
      wait_fd();
      ans = '{4'hE, 4'hD, 4'hF, 4'hF};
      for (int i = 0; i < 4; i++) begin
         chk("an_0045", {12'h0, bus.an}, {12'h0, ans[i]});
         run(P);
      end
      wait_state(2'd1, 1);
      load_word(16'h0000);
      wait_fd();
      ans = '{4'hE, 4'hF, 4'hF, 4'hF};
      for (int i = 0; i < 4; i++) begin
         chk("an_0000", {12'h0, bus.an}, {12'h0, ans[i]});
         chk("bin_0000", {12'h0, bus.bin}, 16'h0000);
         run(P);
      end
      bus.blank_lz = 1'b0;
      run(2);

      // Reset with a pending value while digit 2 is scanned.
      wait_state(2'd1, 1);
      load_word(16'h5A5A);
      wait_state(2'd2, 1);
      chk("pre_rst_pend", {15'h0, bus.pending}, 16'h0001);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_an", {12'h0, bus.an}, 16'h000E);
      chk("async_rst_bin", {12'h0, bus.bin}, 16'h0000);
      chk("async_rst_idx", {14'h0, bus.digit_idx}, 16'h0000);
      chk("async_rst_pend", {15'h0, bus.pending}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      q.delete();
      ones_seen = 0;
      run(20);
      chk("post_rst_pend", {15'h0, bus.pending}, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter: PRESCALE, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: load  input  1  one-cycle request to capture data_in.
REQ-005 Port: data_in  input  16  four BCD/hex nibbles; digit 0 = [3:0], digit 3 = [15:12].
REQ-006 Port: blank_lz  input  1  enables leading-zero blanking.
REQ-007 Port: bin  output  4  nibble of the currently scanned digit; feeds the hex-to-segment encoder.
REQ-008 Port: an  output  4  active-low digit enables; an[i]=0 lights digit i.
REQ-009 Port: digit_idx  output  2  index of the currently scanned digit.
REQ-010 Port: pending  output  1  captured value waiting for the next frame boundary.
REQ-011 Port: frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 Prescaler SHALL count 0..PRESCALE-1 and wrap to 0; tick = (count == PRESCALE-1).
REQ-013 On tick, digit_idx SHALL advance 0->1->2->3->0; otherwise it holds.
REQ-014 Frame boundary = tick while digit_idx==3; frame_done SHALL be 1 in exactly the cycle after that edge, i.e. while digit_idx first reads 0.
REQ-015 Two 16-bit registers: shadow (written by load) and active (displayed).
REQ-016 load=1 SHALL write shadow<=data_in and set pending on the next edge; a load while pending=1 overwrites shadow (last write wins).
REQ-017 At a frame boundary with pending=1, active<=shadow and pending<=0.
REQ-018 load coinciding with a frame boundary: active<=data_in directly, shadow<=data_in, pending<=0.
REQ-019 active SHALL NOT change at any time other than a frame boundary (no mid-frame tearing).
REQ-020 bin SHALL equal active[4*digit_idx+3 : 4*digit_idx]; no combinational path from any input to bin, an or digit_idx.
REQ-021 Digit i (i=1..3) is blanked when blank_lz=1 and nibbles i..3 of active are all zero; digit 0 is never blanked.
REQ-022 an SHALL be ~(4'b0001 << digit_idx) when the scanned digit is not blanked, 4'b1111 when blanked.
REQ-023 blank_lz is sampled continuously; a change affects an from the next cycle.
REQ-024 Exactly one an bit low, or all high, at all times; never two low.
REQ-025 Full scan period SHALL be 4*PRESCALE cycles; each digit lit for exactly PRESCALE cycles.

Reset
REQ-026 rst_n=0 SHALL immediately force count=0, digit_idx=0, active=0, shadow=0, pending=0, frame_done=0, bin=0, an=4'b1110.
REQ-027 Reset assertion mid-frame or with pending=1 SHALL discard the captured value; no load is applied after release.
REQ-028 After rst_n deasserts, the first tick SHALL occur PRESCALE cycles after the first active clock edge.

Verification (PRESCALE=4)
REQ-029 Reset release, no load -> an cycles 1110,1101,1011,0111 every 4 clocks, bin=0 throughout, frame_done pulses every 16 clocks.
REQ-030 load data_in=16'h12AB mid-frame -> pending=1 until boundary; bin sequence B,A,2,1 starts the frame after; pending=0 at the same edge frame_done rises.
REQ-031 Two loads (16'h1111 then 16'h2222) in one frame -> only 2222 displayed; 1111 never appears on bin.
REQ-032 blank_lz=1, active=16'h0045 -> an: 1110,1101,1111,1111; active=16'h0000 -> only digit 0 lit showing 0.
REQ-033 load 16'hBEEF in the boundary cycle -> next frame shows F,E,E,B, pending never asserted.
REQ-034 rst_n pulsed low while pending=1 and digit_idx=2 -> outputs immediately at reset values; after release display shows 0000 and pending=0.
